// File: rtl/axil_block_reader.sv
// AXI-Lite block read master. Fetches num_words_i consecutive DATA_WIDTH words
// starting at base_addr_i and delivers them, in order, on a valid/ready stream.
// Read requests are credit-limited so every outstanding read has a guaranteed
// slot in the output FIFO. This lets r_ready_o stay high for the whole transfer.
//
// Ports:
//   clk_i, rst_i                   clock, asynchronous active-high reset
//   start_i, base_addr_i,
//   num_words_i                    control; sampled on a start accepted in idle
//   busy_o, done_o, error_o        status (done_o one-cycle, error_o sticky)
//   ar_*                           AXI-Lite read address channel
//   r_*                            AXI-Lite read data channel
//   out_data_o/valid_o/ready_i     output stream
module axil_block_reader #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  num_words_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ADDR_WIDTH-1:0] ar_addr_o,
  output logic [2:0]            ar_prot_o,
  output logic                  ar_valid_o,
  input  logic                  ar_ready_i,
  input  logic [DATA_WIDTH-1:0] r_data_i,
  input  logic [1:0]            r_resp_i,
  input  logic                  r_valid_i,
  output logic                  r_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] Stride = ADDR_WIDTH'(DATA_WIDTH / 8);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  done_q, done_d;
  logic                  error_q;
  logic [CNT_WIDTH-1:0]  num_q;
  logic [CNT_WIDTH-1:0]  issued_q;
  logic [CNT_WIDTH-1:0]  received_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PtrW:0]         outst_q;
  logic [PtrW:0]         fifo_cnt_q;
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic          ar_hs;
  logic          r_hs;
  logic          pop;
  logic          start_acc;
  logic [PtrW+1:0] credits;

  // Free FIFO slots not already promised to an in-flight read.
  assign credits = (PtrW + 2)'(FIFO_DEPTH) - {1'b0, fifo_cnt_q} - {1'b0, outst_q};

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign ar_prot_o   = 3'b000;
  assign ar_addr_o   = addr_q;
  // Stable while stalled: credits only shrink through an AR handshake.
  assign ar_valid_o  = (state_q == StRun) && (issued_q < num_q) && (credits != '0);
  assign r_ready_o   = busy_o;
  assign out_valid_o = (fifo_cnt_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];

  assign ar_hs     = ar_valid_o && ar_ready_i;
  assign r_hs      = r_valid_i && r_ready_o;
  assign pop       = out_valid_o && out_ready_i;
  assign start_acc = (state_q == StIdle) && start_i;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          if (num_words_i != '0) state_d = StRun;
          else                   done_d  = 1'b1;
        end
      end
      StRun: begin
        if (received_q == num_q) state_d = StFlush;
      end
      StFlush: begin
        if (fifo_cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      num_q      <= '0;
      issued_q   <= '0;
      received_q <= '0;
      addr_q     <= '0;
      outst_q    <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;

      if (start_acc) begin
        error_q <= 1'b0;
        if (num_words_i != '0) begin
          num_q      <= num_words_i;
          addr_q     <= base_addr_i;
          issued_q   <= '0;
          received_q <= '0;
        end
      end else if (r_hs && (r_resp_i != 2'b00)) begin
        error_q <= 1'b1;
      end

      if (ar_hs) begin
        issued_q <= issued_q + 1'b1;
        addr_q   <= addr_q + Stride;
      end

      if (r_hs) begin
        received_q      <= received_q + 1'b1;
        mem_q[wr_ptr_q] <= r_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end

      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

      if (ar_hs && !r_hs)      outst_q <= outst_q + 1'b1;
      else if (!ar_hs && r_hs) outst_q <= outst_q - 1'b1;

      if (r_hs && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (!r_hs && pop) fifo_cnt_q <= fifo_cnt_q - 1'b1;
    end
  end

endmodule

// File: tb/tb_axil_block_reader.sv
// Self-checking bench for axil_block_reader: a behavioural AXI-Lite slave that
// answers each read with addr ^ MAGIC, randomised stalls, and a reference that
// derives every expected address/word from base + i*4.
module tb_axil_block_reader;

  localparam int unsigned Depth = 4;
  localparam logic [31:0] Magic = 32'hA5A5_A5A5;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [31:0] base_addr_i;
  logic [15:0] num_words_i;
  logic        busy_o, done_o, error_o;
  logic [31:0] ar_addr_o;
  logic [2:0]  ar_prot_o;
  logic        ar_valid_o, ar_ready_i;
  logic [31:0] r_data_i;
  logic [1:0]  r_resp_i;
  logic        r_valid_i, r_ready_o;
  logic [31:0] out_data_o;
  logic        out_valid_o, out_ready_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Scenario knobs read by do_transfer.
  int ar_pct, r_pct, out_pct, ar_hold, out_hold, err_idx, second_start_cyc, abort_after;

  axil_block_reader #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .CNT_WIDTH (16),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .num_words_i(num_words_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .error_o    (error_o),
    .ar_addr_o  (ar_addr_o),
    .ar_prot_o  (ar_prot_o),
    .ar_valid_o (ar_valid_o),
    .ar_ready_i (ar_ready_i),
    .r_data_i   (r_data_i),
    .r_resp_i   (r_resp_i),
    .r_valid_i  (r_valid_i),
    .r_ready_o  (r_ready_o),
    .out_data_o (out_data_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_cfg(input int ar, input int r, input int o, input int arh, input int oh,
                         input int err);
    ar_pct = ar; r_pct = r; out_pct = o; ar_hold = arh; out_hold = oh; err_idx = err;
    second_start_cyc = -1; abort_after = -1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; ar_ready_i = 1'b0; r_valid_i = 1'b0; r_resp_i = 2'b00;
    r_data_i = '0; out_ready_i = 1'b0;
  endtask

  // One complete transfer with slave + stream sink running cycle by cycle.
  task automatic do_transfer(input logic [31:0] base, input int num, input int maxcyc);
    logic [31:0] pend[$];
    int   cyc = 0, ar_hs = 0, r_hs = 0, out_cnt = 0, done_cnt = 0, tail = 0;
    logic err_seen = 1'b0, err_next = 1'b0, r_taken = 1'b0, aborted = 1'b0;
    logic prev_ar_stall = 1'b0, prev_out_stall = 1'b0;
    logic [31:0] prev_ar_addr = '0, prev_out_data = '0, exp;
    logic exp_err;
    while (cyc < maxcyc && tail < 3) begin
      @(negedge clk);
      if (r_taken) begin r_valid_i = 1'b0; r_taken = 1'b0; end
      start_i     = (cyc == 0) || (cyc == second_start_cyc);
      base_addr_i = (cyc == 0) ? base : 32'h5555_0000;
      num_words_i = (cyc == 0) ? 16'(num) : 16'd7;
      ar_ready_i  = (cyc >= ar_hold) && ($urandom_range(0, 99) < ar_pct);
      if (!r_valid_i && pend.size() > 0 && $urandom_range(0, 99) < r_pct) begin
        r_valid_i = 1'b1;
        r_data_i  = pend[0] ^ Magic;
        r_resp_i  = (r_hs == err_idx) ? 2'b10 : 2'b00;
      end
      out_ready_i = (cyc >= out_hold) && ($urandom_range(0, 99) < out_pct);
      #1;
      if (prev_ar_stall) begin
        n_checks++;
        if (ar_valid_o !== 1'b1 || ar_addr_o !== prev_ar_addr)
          $display("FAIL ar_stable: cyc %0d valid %b addr %h want valid 1 addr %h",
                   cyc, ar_valid_o, ar_addr_o, prev_ar_addr);
        else n_pass++;
      end
      if (prev_out_stall) begin
        n_checks++;
        if (out_valid_o !== 1'b1 || out_data_o !== prev_out_data)
          $display("FAIL out_stable: cyc %0d valid %b data %h want valid 1 data %h",
                   cyc, out_valid_o, out_data_o, prev_out_data);
        else n_pass++;
      end
      if (cyc > 0) begin
        n_checks++;
        if (error_o !== err_seen)
          $display("FAIL error_track: cyc %0d got %b want %b", cyc, error_o, err_seen);
        else n_pass++;
      end
      if (out_hold > 0 && cyc == out_hold) begin
        n_checks++;
        if (ar_hs != Depth || ar_valid_o !== 1'b0)
          $display("FAIL credit_cap: ar handshakes %0d ar_valid %b want %0d and 0",
                   ar_hs, ar_valid_o, Depth);
        else n_pass++;
      end
      if (ar_valid_o && ar_ready_i) begin
        exp = base + 32'(ar_hs) * 32'd4;
        n_checks++;
        if (ar_addr_o !== exp || ar_hs >= num)
          $display("FAIL ar_addr: #%0d got %h want %h (num %0d)", ar_hs, ar_addr_o, exp, num);
        else n_pass++;
        pend.push_back(ar_addr_o);
        ar_hs++;
      end
      if (r_valid_i && r_ready_o) begin
        if (r_resp_i != 2'b00) err_next = 1'b1;
        void'(pend.pop_front());
        r_hs++;
        r_taken = 1'b1;
      end
      if (out_valid_o && out_ready_i) begin
        exp = (base + 32'(out_cnt) * 32'd4) ^ Magic;
        n_checks++;
        if (out_data_o !== exp || out_cnt >= num)
          $display("FAIL out_data: #%0d got %h want %h", out_cnt, out_data_o, exp);
        else n_pass++;
        out_cnt++;
      end
      if (done_o) done_cnt++;
      if (done_cnt > 0) tail++;
      err_seen       = err_next;
      prev_ar_stall  = ar_valid_o && !ar_ready_i;
      prev_ar_addr   = ar_addr_o;
      prev_out_stall = out_valid_o && !out_ready_i;
      prev_out_data  = out_data_o;
      cyc++;
      if (abort_after >= 0 && out_cnt >= abort_after) begin aborted = 1'b1; break; end
    end
    if (!aborted) begin
      idle_inputs();
      exp_err = (err_idx >= 0) && (err_idx < num);
      n_checks++;
      if (done_cnt != 1) $display("FAIL done_count: got %0d want 1", done_cnt);
      else n_pass++;
      n_checks++;
      if (ar_hs != num) $display("FAIL ar_count: got %0d want %0d", ar_hs, num);
      else n_pass++;
      n_checks++;
      if (out_cnt != num) $display("FAIL out_count: got %0d want %0d", out_cnt, num);
      else n_pass++;
      n_checks++;
      if (error_o !== exp_err) $display("FAIL error_final: got %b want %b", error_o, exp_err);
      else n_pass++;
      n_checks++;
      if (busy_o !== 1'b0) $display("FAIL busy_end: got %b want 0", busy_o);
      else n_pass++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({busy_o, done_o, error_o, ar_addr_o, ar_prot_o, ar_valid_o, r_ready_o, out_data_o,
         out_valid_o} !== '0)
      $display("FAIL %s: busy %b done %b err %b ar_addr %h ar_valid %b r_ready %b out %h/%b want all 0",
               tag, busy_o, done_o, error_o, ar_addr_o, ar_valid_o, r_ready_o, out_data_o,
               out_valid_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; idle_inputs(); base_addr_i = '0; num_words_i = '0;
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset_hold");
    @(negedge clk); rst_i = 1'b0;
    #1 check_all_zero("reset_release");
  endtask

  task automatic test_basic();
    set_cfg(100, 100, 100, 0, 0, -1);
    do_transfer(32'h0000_1000, 4, 200);
  endtask

  task automatic test_backpressure();
    set_cfg(100, 100, 100, 0, 50, -1);
    do_transfer(32'h0000_4000, 8, 400);
  endtask

  task automatic test_error();
    set_cfg(100, 100, 100, 0, 0, 1);
    do_transfer(32'h0000_8000, 3, 200);
  endtask

  task automatic test_zero_count();
    @(negedge clk);
    start_i = 1'b1; num_words_i = 16'd0; base_addr_i = 32'h0000_3000;
    @(negedge clk);
    start_i = 1'b0;
    #1;
    n_checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || ar_valid_o !== 1'b0 || error_o !== 1'b0)
      $display("FAIL zero_done: done %b busy %b ar_valid %b err %b want 1 0 0 0",
               done_o, busy_o, ar_valid_o, error_o);
    else n_pass++;
    @(negedge clk); #1;
    n_checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || ar_valid_o !== 1'b0)
      $display("FAIL zero_after: done %b busy %b ar_valid %b want 0 0 0",
               done_o, busy_o, ar_valid_o);
    else n_pass++;
  endtask

  task automatic test_stall_wrap();
    set_cfg(70, 50, 50, 5, 0, -1);
    do_transfer(32'hFFFF_FFF8, 64, 4000);
  endtask

  task automatic test_reset_mid();
    set_cfg(100, 100, 100, 0, 0, -1);
    abort_after = 2;
    do_transfer(32'h0000_2000, 6, 200);
    @(negedge clk);
    rst_i = 1'b1; idle_inputs();
    #1 check_all_zero("reset_mid");
    @(negedge clk); rst_i = 1'b0;
    set_cfg(100, 100, 100, 0, 0, -1);
    second_start_cyc = 3;
    do_transfer(32'h0000_2400, 2, 200);
    second_start_cyc = -1;
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      set_cfg(int'($urandom_range(30, 100)), int'($urandom_range(30, 100)),
              int'($urandom_range(30, 100)), 0, 0, -1);
      do_transfer($urandom & 32'hFFFF_FFFC, int'($urandom_range(1, 20)), 3000);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_zero_count();
    test_stall_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_block_reader.md
Name: axil_block_reader

Overview:
- AXI-Lite read master that fetches a contiguous block of 32-bit words and delivers them in order on a valid/ready stream.
- Control comes from CSR outputs: base address, word count, start pulse.
- Drives the AXI-Lite bus that is converted to full AXI for the master port.
- Feeds input data to the CGRA under test.
- Replaces single-word test reads with credit-controlled multi-outstanding reads.

Parameters:
ADDR_WIDTH, 32, AXI-Lite address width
DATA_WIDTH, 32, AXI-Lite data width; address stride = DATA_WIDTH/8
CNT_WIDTH, 16, width of word count
FIFO_DEPTH, 4, output buffer depth, power of two ≥ 2; also the cap on outstanding reads

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  one-cycle start pulse
base_addr_i  in  ADDR_WIDTH  first word address, sampled on accepted start
num_words_i  in  CNT_WIDTH  words to read, sampled on accepted start
busy_o  out  1  transfer in progress
done_o  out  1  one-cycle completion pulse
error_o  out  1  sticky: some R beat had resp != OKAY
ar_addr_o  out  ADDR_WIDTH  AR address
ar_prot_o  out  3  constant 3'b000
ar_valid_o  out  1  AR valid
ar_ready_i  in  1  AR ready
r_data_i  in  DATA_WIDTH  R data
r_resp_i  in  2  R response
r_valid_i  in  1  R valid
r_ready_o  out  1  R ready
out_data_o  out  DATA_WIDTH  stream data
out_valid_o  out  1  stream valid
out_ready_i  in  1  stream ready

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Counters, FIFO pointers and error_o cleared. Reset mid-transfer abandons it; no done_o.
- FSM states: IDLE, RUN, FLUSH.
- IDLE, start_i=1, num_words_i>0:
  - Latch base address and count.
  - Clear error_o.
  - Go to RUN; busy_o=1 from next cycle.
- IDLE, start_i=1, num_words_i=0:
  - done_o pulses next cycle.
  - No AR issued; error_o cleared.
- start_i while busy_o=1 is ignored.
- RUN, AR channel:
  - ar_valid_o=1 while issued<num and credits>0.
  - credits = FIFO_DEPTH − fifo_count − outstanding.
  - First ar_valid_o appears one cycle after the accepted start.
  - ar_addr_o = base + issued×(DATA_WIDTH/8), modulo 2^ADDR_WIDTH (wraps silently).
  - Once asserted, ar_valid_o and ar_addr_o stay stable until ar_ready_i.
  - issued increments on each AR handshake.
- RUN, R channel:
  - r_ready_o=1 whenever busy_o=1. Credits guarantee FIFO space.
  - Each R handshake pushes r_data_i into the FIFO and increments received.
  - resp != 2'b00 sets error_o; the data is still pushed.
- RUN → FLUSH when received==num.
- FLUSH → IDLE when FIFO empty. done_o pulses on the cycle of that transition; busy_o drops with it.
- Output stream:
  - FIFO is registered: out_valid_o rises the cycle after the R beat is accepted.
  - out_data_o is held stable while out_valid_o && !out_ready_i.
  - Order is preserved.
- Simultaneous FIFO push and pop in one cycle is legal; count is unchanged.
- Full FIFO cannot overflow; credits block AR issue.
- Outstanding counter:
  - +1 on AR handshake, −1 on R handshake, unchanged if both happen together.
  - Width is clog2(FIFO_DEPTH)+1.
- R beats arriving while busy_o=0 are not accepted (r_ready_o=0).

Test Plan:
1. base=0x1000, num=4, zero-wait slave returning addr^0xA5A5A5A5, out_ready=1 → ARs to 0x1000/0x1004/0x1008/0x100C; outputs 0xA5A5B5A5, 0xA5A5B5A1, 0xA5A5B5AD, 0xA5A5B5A9 in order; one done_o pulse; error_o=0.
2. num=8, FIFO_DEPTH=4, out_ready=0 for 50 cycles → exactly 4 AR handshakes, then ar_valid_o=0. Release out_ready → remaining 4 ARs issue; all 8 words delivered; done_o once.
3. num=0 start → done_o one cycle later; ar_valid_o never asserted; busy_o stays 0.
4. num=3, slave returns SLVERR on word 2 → error_o=1 from that beat onward, all 3 words still output, done_o pulses. Next start clears error_o.
5. ar_ready_i held 0 for 5 cycles, with random stalls on r_valid and out_ready → ar_addr_o stable while stalled; no data loss or duplication over 64 words. base=0xFFFFFFF8 wraps to 0x00000000.
6. rst_i asserted mid-transfer (after 2 of 6 words) → all outputs 0 immediately. A new start with num=2 completes normally. A second start_i during busy is ignored (count unchanged).
